// File: rtl/systolic_feeder.sv
// Feed stage for an N x N systolic array: reads A columns / B rows, skews lane i by i cycles.
// Optional cycle counter output enabled by defining SYSTOLIC_FEEDER_PERF_EN.
module systolic_feeder #(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    output logic [KW-1:0]   a_addr,
    input  logic [N*8-1:0]  a_rdata,
    output logic [KW-1:0]   b_addr,
    input  logic [N*8-1:0]  b_rdata,
    output logic            rd_en,
    output logic [N*8-1:0]  west_data,
    output logic [N*8-1:0]  north_data,
    output logic            acc_clr,
    output logic            busy,
`ifdef SYSTOLIC_FEEDER_PERF_EN
    output logic            done,
    output logic [31:0]     cycle_cnt
`else
    output logic            done
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DRAIN_LEN = 3 * N;
    localparam int DW        = $clog2(DRAIN_LEN + 1);

    state_t          state;
    logic [KW-1:0]   k_lat;
    logic [KW-1:0]   addr;
    logic [DW-1:0]   drain_cnt;
    logic            dv;

    assign a_addr = addr;
    assign b_addr = addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k_lat     <= '0;
            addr      <= '0;
            drain_cnt <= '0;
            rd_en     <= 1'b0;
            acc_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_lat   <= k_len;
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        acc_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    addr      <= '0;
                    drain_cnt <= '0;
                    if (k_lat != '0) begin
                        state <= FEED;
                        rd_en <= 1'b1;
                    end else begin
                        state <= DRAIN;
                    end
                end
                FEED: begin
                    if (addr == k_lat - KW'(1)) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                        addr  <= '0;
                    end else begin
                        addr <= addr + KW'(1);
                    end
                end
                DRAIN: begin
                    // Long enough for the last skewed operand to ripple through the array.
                    if (drain_cnt == DW'(DRAIN_LEN - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data arrives one cycle after rd_en; dv marks those capture cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dv <= 1'b0;
        else     dv <= rd_en;
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [7:0] w_sr [0:i];
        logic [7:0] n_sr [0:i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= i; s++) begin
                    w_sr[s] <= 8'h00;
                    n_sr[s] <= 8'h00;
                end
            end else begin
                w_sr[0] <= dv ? a_rdata[i*8 +: 8] : 8'h00;
                n_sr[0] <= dv ? b_rdata[i*8 +: 8] : 8'h00;
                for (int s = 1; s <= i; s++) begin
                    w_sr[s] <= w_sr[s-1];
                    n_sr[s] <= n_sr[s-1];
                end
            end
        end

        assign west_data[i*8 +: 8]  = w_sr[i];
        assign north_data[i*8 +: 8] = n_sr[i];
    end

`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [31:0] run_cnt;

    // run_cnt counts the start cycle too, so the DONE cycle adds one more.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt   <= '0;
            cycle_cnt <= '0;
        end else begin
            if (state == IDLE && start) run_cnt <= 32'd1;
            else if (busy)              run_cnt <= run_cnt + 32'd1;
            if (state == DONE)          cycle_cnt <= run_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: timing of acc_clr/rd_en/busy/done, lane skew, reset abort.
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic [KW-1:0]   a_addr, b_addr;
    logic [N*8-1:0]  a_rdata = '0, b_rdata = '0;
    logic            rd_en;
    logic [N*8-1:0]  west_data, north_data;
    logic            acc_clr, busy, done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [31:0]     cycle_cnt;
`endif

    int total = 0;
    int bad   = 0;

    systolic_feeder #(.N(N), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .a_addr(a_addr), .a_rdata(a_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
        .rd_en(rd_en), .west_data(west_data), .north_data(north_data),
        .acc_clr(acc_clr), .busy(busy),
`ifdef SYSTOLIC_FEEDER_PERF_EN
        .done(done), .cycle_cnt(cycle_cnt)
`else
        .done(done)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read buffers: A[i][k] = 16*i+k+1, B[k][j] = 16*k+j+0x81; junk when not read.
    always @(posedge clk) begin
        if (rd_en) begin
            for (int i = 0; i < N; i++) begin
                a_rdata[i*8 +: 8] <= 8'(16*i + int'(a_addr) + 1);
                b_rdata[i*8 +: 8] <= 8'(16*int'(b_addr) + i + 'h81);
            end
        end else begin
            a_rdata <= $urandom;
            b_rdata <= $urandom;
        end
    end

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_w(input int i, input int c, input int k);
        int kk = c - 4 - i;
        if (kk >= 0 && kk < k) return 8'(16*i + kk + 1);
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_n(input int j, input int c, input int k);
        int kk = c - 4 - j;
        if (kk >= 0 && kk < k) return 8'(16*kk + j + 'h81);
        return 8'h00;
    endfunction

    // Called at a negedge: that cycle is cycle 0. Returns at the negedge of cycle K+3+3N.
    task automatic run_op(input int k, input int ign_a, input int ign_b);
        int last = k + 2 + 3*N;
        start = 1'b1;
        k_len = KW'(k);
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            start = (c == ign_a || c == ign_b);
            k_len = KW'(7);
            chk("acc_clr", c, 32'(acc_clr), 32'(c == 1));
            chk("busy", c, 32'(busy), 32'(c >= 1 && c <= last));
            chk("done", c, 32'(done), 32'(c == last));
            chk("rd_en", c, 32'(rd_en), 32'(c >= 2 && c <= k + 1));
            if (c >= 2 && c <= k + 1) begin
                chk("a_addr", c, 32'(a_addr), 32'(c - 2));
                chk("b_addr", c, 32'(b_addr), 32'(c - 2));
            end
            for (int i = 0; i < N; i++) begin
                chk($sformatf("west%0d", i), c, 32'(west_data[i*8 +: 8]), 32'(exp_w(i, c, k)));
                chk($sformatf("north%0d", i), c, 32'(north_data[i*8 +: 8]), 32'(exp_n(i, c, k)));
            end
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset values while rst is held
        #1;
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        chk("rst_acc_clr", 0, 32'(acc_clr), 32'd0);
        chk("rst_rd_en", 0, 32'(rd_en), 32'd0);
        chk("rst_west", 0, west_data, 32'd0);
        chk("rst_north", 0, north_data, 32'd0);
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk("rst_cycle_cnt", 0, cycle_cnt, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic skew with K=4: done at cycle 18
        run_op(4, -1, -1);
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk("perf_cnt", 0, cycle_cnt, 32'd19);
`endif

        // Abort mid-FEED with reset
        start = 1'b1;
        k_len = KW'(4);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_rd_en_before", 3, 32'(rd_en), 32'd1);
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk("perf_hold_midop", 3, cycle_cnt, 32'd19);
`endif
        rst = 1'b1;
        #1;
        chk("abort_busy", 3, 32'(busy), 32'd0);
        chk("abort_rd_en", 3, 32'(rd_en), 32'd0);
        chk("abort_acc_clr", 3, 32'(acc_clr), 32'd0);
        chk("abort_addr", 3, 32'(a_addr), 32'd0);
        chk("abort_west", 3, west_data, 32'd0);
        chk("abort_north", 3, north_data, 32'd0);
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk("abort_cycle_cnt", 3, cycle_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_abort_done", c, 32'(done), 32'd0);
            chk("post_abort_busy", c, 32'(busy), 32'd0);
        end

        // K=2 after reset: done at cycle 16
        run_op(2, -1, -1);
        // K=0 back-to-back: done at cycle 14, no reads
        run_op(0, -1, -1);
        // Starts at cycle 3 and in the DONE cycle are ignored
        run_op(4, 3, 4 + 2 + 3*N);
        // Start in the cycle after DONE is accepted
        run_op(3, -1, -1);
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk("perf_cnt_k3", 0, cycle_cnt, 32'd18);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
